// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
// master: operand producer / result consumer side; slave: the arithmetic unit.
interface pipelined_add_sub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, carryin, sub, out_ready,
        input  in_ready, out_valid, sum, carryout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, carryin, sub, out_ready,
        output in_ready, out_valid, sum, carryout, overflow, zero
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract unit: WIDTH-bit ripple add split into STAGES registered
// chunks of CW = WIDTH/STAGES bits, carry handed from stage to stage.
// Optional build macro ADDSUB_SATURATE_EN clamps sum to signed max/min on overflow.
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input logic               clk,
    input logic               reset,
    pipelined_add_sub_if.slave bus
);
    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_add_sub: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    // Per-stage state: operands ride along so later stages can add their chunk;
    // res holds the already-computed low chunks (skew registers).
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              stall;

    // Next-state for every stage; whole pipeline holds while the output is stalled.
    always_comb begin
        stall        = valid_q[LAST] & ~bus.out_ready;
        bus.in_ready = ~stall;
        valid_d      = valid_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            logic             v_src;
            logic             c_src;
            logic [WIDTH-1:0] a_src;
            logic [WIDTH-1:0] b_src;
            logic [WIDTH-1:0] r_src;
            logic [CW:0]      chunk;
            logic             msb_cin;
            logic             ovf;
            if (k == 0) begin
                v_src = bus.in_valid;
                a_src = bus.a;
                b_src = bus.sub ? ~bus.b : bus.b;
                c_src = bus.sub | bus.carryin;  // subtract forces +1, carryin ignored
                r_src = '0;
            end else begin
                v_src = valid_q[k-1];
                a_src = a_q[k-1];
                b_src = b_q[k-1];
                c_src = carry_q[k-1];
                r_src = res_q[k-1];
            end
            chunk = {1'b0, a_src[k*CW +: CW]} + {1'b0, b_src[k*CW +: CW]}
                  + {{CW{1'b0}}, c_src};
            r_src[k*CW +: CW] = chunk[CW-1:0];
            // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
            msb_cin = r_src[WIDTH-1] ^ a_src[WIDTH-1] ^ b_src[WIDTH-1];
            ovf     = chunk[CW] ^ msb_cin;
`ifdef ADDSUB_SATURATE_EN
            // Overflow implies both operands share a sign; clamp toward it.
            if (k == LAST && ovf) begin
                r_src = a_src[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
            if (!stall) begin
                valid_d[k] = v_src;
                carry_d[k] = chunk[CW];
                a_d[k]     = a_src;
                b_d[k]     = b_src;
                res_d[k]   = r_src;
                if (k == LAST) begin
                    ovf_d  = ovf;
                    zero_d = (r_src == '0);
                end
            end
        end
    end

    // Stage registers; async reset discards any in-flight beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign bus.out_valid = valid_q[LAST];
    assign bus.sum       = res_q[LAST];
    assign bus.carryout  = carry_q[LAST];
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule
